// File: rtl/serial_add_sub_if.sv
// serial_add_sub_if: operand/control bus and result outputs of the bit-serial adder/subtractor
interface serial_add_sub_if #(parameter int WIDTH = 8);
    logic             i_en_n;
    logic             i_start;
    logic             i_sub;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_s;
    logic             o_c_out;
    logic             o_ovf;
    modport master (output i_en_n, i_start, i_sub, i_a, i_b,
                    input  o_busy, o_done, o_s, o_c_out, o_ovf);
    modport slave  (input  i_en_n, i_start, i_sub, i_a, i_b,
                    output o_busy, o_done, o_s, o_c_out, o_ovf);
endinterface

// File: rtl/serial_add_sub.sv
// serial_add_sub: bit-serial two's-complement adder/subtractor, one bit per enabled clock
module serial_add_sub #(
    parameter int WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    serial_add_sub_if.slave       bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;
    state_t           r_state;
    logic [WIDTH-1:0] r_a, r_b, r_res, r_s;
    logic [CW-1:0]    r_cnt;
    logic             r_c, r_c_out, r_ovf, r_busy, r_done;
    logic [3:0]       w_sum_tbl, w_cy_tbl;
    logic [1:0]       w_ab;
    logic             w_sum, w_cy, w_last;
    logic [WIDTH-1:0] w_res_next;
    // full-adder bit as two 4:1 muxes selected by the operand LSBs
    assign w_ab       = {r_a[0], r_b[0]};
    assign w_sum_tbl  = {r_c, ~r_c, ~r_c, r_c};
    assign w_cy_tbl   = {1'b1, r_c, r_c, 1'b0};
    assign w_sum      = w_sum_tbl[w_ab];
    assign w_cy       = w_cy_tbl[w_ab];
    assign w_last     = (r_cnt == CW'(WIDTH - 1));
    assign w_res_next = {w_sum, r_res[WIDTH-1:1]};
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_s     <= '0;
            r_cnt   <= '0;
            r_c     <= 1'b0;
            r_c_out <= 1'b0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if (!bus.i_en_n) begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (bus.i_start) begin
                        r_a     <= bus.i_a;
                        r_b     <= bus.i_sub ? ~bus.i_b : bus.i_b;
                        r_c     <= bus.i_sub;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_res <= w_res_next;
                    r_c   <= w_cy;
                    r_cnt <= r_cnt + 1'b1;
                    // results become visible only once the last bit is in
                    if (w_last) begin
                        r_s     <= w_res_next;
                        r_c_out <= w_cy;
                        r_ovf   <= r_c ^ w_cy;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= FINISH;
                    end
                end
                FINISH: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign bus.o_busy  = r_busy;
    assign bus.o_done  = r_done;
    assign bus.o_s     = r_s;
    assign bus.o_c_out = r_c_out;
    assign bus.o_ovf   = r_ovf;
endmodule

// File: doc/serial_add_sub.md
SERIAL_ADD_SUB -- requirements
Module: serial_add_sub

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; SHALL be legal for WIDTH >= 2.
REQ-002 CLK  input  1  sole clock; all state SHALL change on its rising edge, except for reset.
REQ-003 RST_N  input  1  reset, asynchronous, active-low.
REQ-004 EN_N  input  1  active-low enable; high SHALL freeze all internal state and outputs.
REQ-005 START  input  1  request to begin an operation; sampled only in IDLE with EN_N low.
REQ-006 SUB  input  1  operation select, captured with START: 0 = A+B, 1 = A-B.
REQ-007 A  input  WIDTH  first operand, captured with START.
REQ-008 B  input  WIDTH  second operand, captured with START.
REQ-009 BUSY  output  1  high while in SHIFT state.
REQ-010 DONE  output  1  single-cycle completion strobe.
REQ-011 S  output  WIDTH  sum/difference result.
REQ-012 C_OUT  output  1  final carry out of MSB; for SUB, 1 = no borrow.
REQ-013 OVF  output  1  two's-complement signed overflow of the result.

Function
REQ-014 States SHALL be IDLE, SHIFT and FINISH.
REQ-015 IDLE: on a rising edge with START=1 and EN_N=0 the block SHALL load A into the A shift register, load B (if SUB=0) or ~B (if SUB=1), set carry flip-flop to SUB, clear bit counter, and go to SHIFT.
REQ-016 SHIFT: each enabled edge SHALL form one full-adder bit from the operand LSBs and the carry flip-flop, shift the sum bit into the result register from the MSB side, shift both operand registers right by one, update the carry flip-flop, and increment the counter.
REQ-017 The full-adder bit SHALL be built as sum = mux4({a,b}; c, ~c, ~c, c) and carry = mux4({a,b}; 0, c, c, 1).
REQ-018 After exactly WIDTH enabled SHIFT edges, the FSM SHALL go to FINISH.
REQ-019 On that same edge, S, C_OUT and OVF SHALL update.
REQ-020 OVF SHALL equal the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1.
REQ-021 FINISH SHALL last one enabled cycle with DONE=1, then return to IDLE.
REQ-022 Latency: with EN_N held low, DONE SHALL be high in the cycle following edge WIDTH+1, counting the START-capture edge as edge 1.
REQ-023 S, C_OUT and OVF SHALL hold their values from the completion edge until the completion edge of the next operation; they SHALL NOT show partial results.
REQ-024 START SHALL be ignored in SHIFT and FINISH; it SHALL NOT restart, queue or corrupt the operation in progress.
REQ-025 EN_N high in any state SHALL stall the FSM, counter, shift registers and carry.
REQ-026 While stalled, DONE SHALL stay at its current value; each stalled cycle SHALL add one cycle of latency.
REQ-027 BUSY SHALL be 1 exactly while in SHIFT; BUSY and DONE SHALL never be high together.
REQ-028 Arithmetic SHALL be modulo 2^WIDTH; C_OUT SHALL carry the extra bit.
REQ-029 An operation SHALL use only the A, B and SUB values captured at START; later input changes SHALL have no effect.

Reset
REQ-030 RST_N low SHALL immediately, without a clock, force IDLE and clear the counter, carry, and operand and result registers.
REQ-031 During reset, S=0, C_OUT=0, OVF=0, BUSY=0 and DONE=0.
REQ-032 Reset asserted mid-operation SHALL abort the operation with no DONE pulse.
REQ-033 The first START accepted after RST_N rises SHALL behave as from power-up.

Verification (WIDTH=8)
REQ-034 ADD A=0x5A, B=0x33 -> after 9 edges DONE=1 for one cycle, S=0x8D, C_OUT=0, OVF=1.
REQ-035 ADD A=0xFF, B=0x01 -> S=0x00, C_OUT=1, OVF=0; SUB A=0x10, B=0x20 -> S=0xF0, C_OUT=0, OVF=0.
REQ-036 SUB A=0x80, B=0x01 -> S=0x7F, C_OUT=1, OVF=1; START pulsed in SHIFT at cycle 3 with other operands -> result unchanged, exactly one DONE.
REQ-037 EN_N high for 3 cycles mid-SHIFT -> DONE at edge 12 instead of 9, S correct, BUSY held during the stall.
REQ-038 RST_N low at SHIFT cycle 4 -> all outputs 0 asynchronously, no DONE; a new ADD 0x01+0x01 afterwards -> S=0x02.
REQ-039 Random operands with WIDTH in {2, 8, 16}, checked against a reference model -> S, C_OUT and OVF match for 1000 operations each.
